// File: rtl/fft_dma_pkg.sv
// Shared types and helpers for the FFT DMA wrapper: packer state encoding,
// DMA beat size codes and the complex-sample packing function.
package fft_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CTRL   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DONE   = 3'd3
  } pack_state_e;

  localparam logic [2:0] DMA_SIZE_WORD  = 3'd2;
  localparam logic [2:0] DMA_SIZE_DWORD = 3'd3;

  // Callers zero-extend components to 16 bits, so no sign bits leak into the word.
  function automatic logic [31:0] pack_sample(input logic [15:0] re, input logic [15:0] im);
    return {im, re};
  endfunction

endpackage

// File: rtl/fft_out_fifo2.sv
// Two-entry synchronous FIFO for the packer output stage; push and pop may
// occur in the same cycle. The caller never pushes into a full FIFO without popping.
module fft_out_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fft_out_dma_packer.sv
// Streams the FFT result buffer onto the DMA write channel after one control request.
// Optional FFT_OUT_PACK2_EN packs two samples per 64-bit beat.
//   state  | meaning
//   IDLE   | waiting for start
//   CTRL   | write-control request pending
//   STREAM | reading buffer, emitting beats
//   DONE   | one-cycle completion pulse
module fft_out_dma_packer
  import fft_dma_pkg::*;
#(
  parameter int N_SAMPLES = 64,
  parameter int SAMPLE_W  = 12,
  parameter int DST_INDEX = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         buf_rd_en,
  output logic [$clog2(N_SAMPLES)-1:0] buf_rd_addr,
  input  logic [SAMPLE_W-1:0]          buf_rd_real,
  input  logic [SAMPLE_W-1:0]          buf_rd_imag,
  output logic                         dma_write_ctrl_valid,
  input  logic                         dma_write_ctrl_ready,
  output logic [31:0]                  dma_write_ctrl_data_index,
  output logic [31:0]                  dma_write_ctrl_data_length,
  output logic [2:0]                   dma_write_ctrl_data_size,
  output logic                         dma_write_chnl_valid,
  input  logic                         dma_write_chnl_ready,
  output logic [63:0]                  dma_write_chnl_data,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  debug
);

`ifdef FFT_OUT_PACK2_EN
  localparam bit PACK2 = 1'b1;
`else
  localparam bit PACK2 = 1'b0;
`endif

  localparam int AW      = $clog2(N_SAMPLES);
  localparam int CW      = $clog2(N_SAMPLES + 1);
  localparam int N_BEATS = PACK2 ? N_SAMPLES / 2 : N_SAMPLES;

  pack_state_e    state_q, state_d;
  logic [CW-1:0]  rd_cnt;
  logic [CW-1:0]  beat_cnt;
  logic           rd_pend;
  logic           pend_odd;
  logic [31:0]    lo_q;
  logic [31:0]    cur_word;
  logic           rd_left;
  logic           push, pop, last_pop;
  logic [2:0]     occ_next;
  logic [63:0]    push_data;
  logic           fifo_full, fifo_empty;
  logic [1:0]     fifo_count;
  logic [63:0]    fifo_head;

  assign cur_word = pack_sample(16'(buf_rd_real), 16'(buf_rd_imag));
  assign rd_left  = (rd_cnt < CW'(N_SAMPLES));
  assign pop      = !fifo_empty && dma_write_chnl_ready;
  assign push     = rd_pend && (!PACK2 || pend_odd);
  assign last_pop = pop && (beat_cnt == CW'(N_BEATS - 1));
  // Occupancy after this cycle's push/pop; crediting the pop keeps full rate with no bubbles.
  assign occ_next = {1'b0, fifo_count} - {2'b0, pop} + {2'b0, push};

  always_comb begin
    buf_rd_en = 1'b0;
    if (state_q == ST_STREAM && rd_left && !(fifo_full && !pop))
      buf_rd_en = (PACK2 && rd_cnt[0]) || (occ_next < 3'd2);
  end

  assign buf_rd_addr = buf_rd_en ? rd_cnt[AW-1:0] : '0;
  assign push_data   = PACK2 ? {cur_word, lo_q} : {32'd0, cur_word};

  fft_out_fifo2 #(.W(64)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_CTRL;
      ST_CTRL:   if (dma_write_ctrl_ready) state_d = ST_STREAM;
      ST_STREAM: if (last_pop) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rd_cnt   <= '0;
      beat_cnt <= '0;
      rd_pend  <= 1'b0;
      pend_odd <= 1'b0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) begin
        rd_cnt   <= '0;
        beat_cnt <= '0;
        rd_pend  <= 1'b0;
        pend_odd <= 1'b0;
      end else begin
        rd_pend  <= buf_rd_en;
        pend_odd <= rd_cnt[0];
        if (buf_rd_en) rd_cnt <= rd_cnt + 1'b1;
        if (pop && beat_cnt < CW'(N_BEATS)) beat_cnt <= beat_cnt + 1'b1;
        if (rd_pend && !pend_odd) lo_q <= cur_word;
      end
    end
  end

  assign dma_write_ctrl_valid       = (state_q == ST_CTRL);
  assign dma_write_ctrl_data_index  = dma_write_ctrl_valid ? 32'(DST_INDEX) : 32'd0;
  assign dma_write_ctrl_data_length = dma_write_ctrl_valid ? 32'(N_BEATS) : 32'd0;
  assign dma_write_ctrl_data_size   = !dma_write_ctrl_valid ? 3'd0 :
                                      (PACK2 ? DMA_SIZE_DWORD : DMA_SIZE_WORD);
  assign dma_write_chnl_valid = !fifo_empty;
  assign dma_write_chnl_data  = fifo_head;
  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign debug = {16'(beat_cnt), 13'd0, state_q};

endmodule
